// File: rtl/pooling_feeder.sv
// Purpose : sequences convolution rows into the max-pooling cell array, one lane per window column group.
// Latency : out_valid rises POOL_SIZE+1 edges after the last row of a window is accepted.
// Backpressure : stalls in CAPTURE while out_data is held, with row_ready low and MIN driven to the array.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   row_in/row_valid/row_ready  one convolution row per handshake (word 0 at MSB end)
//   pool_data, pool_clear   drive the array's data_in/clear (lane 0 at MSB end)
//   pool_result             array data_out, sampled in CAPTURE
//   out_data/out_valid/out_ready  captured window maxima
module pooling_feeder #(
  parameter int OUTPUT_SIZE = 3,
  parameter int POOL_SIZE   = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [OUTPUT_SIZE*POOL_SIZE*DATA_WIDTH-1:0] row_in,
  input  logic                              row_valid,
  output logic                              row_ready,
  output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] pool_data,
  output logic                              pool_clear,
  input  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] pool_result,
  output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int N  = OUTPUT_SIZE * POOL_SIZE;
  localparam int CW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(POOL_SIZE - 1);
  // Most negative two's complement value: neutral element for max.
  localparam logic [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_CLEAR,
    S_WAIT_ROW,
    S_FEED,
    S_CAPTURE
  } state_t;

  state_t state, state_nxt;

  logic [N*DATA_WIDTH-1:0] row_buf;
  logic [CW-1:0]           k;
  logic [CW-1:0]           r;
  logic                    load;
  logic [DATA_WIDTH-1:0]   row_word [N];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_nxt  = state;
    row_ready  = 1'b0;
    pool_clear = 1'b0;
    load       = 1'b0;
    case (state)
      S_CLEAR: begin
        pool_clear = 1'b1;
        state_nxt  = S_WAIT_ROW;
      end
      S_WAIT_ROW: begin
        row_ready = 1'b1;
        if (row_valid) begin
          state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        if (k == LAST) begin
          state_nxt = (r == LAST) ? S_CAPTURE : S_WAIT_ROW;
        end
      end
      S_CAPTURE: begin
        // Load when the output register is empty or being drained this cycle.
        if (!out_valid || out_ready) begin
          load      = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Unpack the buffered row so lane/column selection is a plain index.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_word[i] = row_buf[(N-i)*DATA_WIDTH-1 -: DATA_WIDTH];
    end
  end

  // Lane j carries column k of its horizontal group; MIN elsewhere keeps the array unchanged.
  always_comb begin
    logic [IW-1:0] idx;
    idx       = '0;
    pool_data = {OUTPUT_SIZE{MIN}};
    if (state == S_FEED) begin
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        idx = IW'(j * POOL_SIZE) + IW'(k);
        pool_data[(OUTPUT_SIZE-j)*DATA_WIDTH-1 -: DATA_WIDTH] = row_word[idx];
      end
    end
  end

  // Datapath registers: row buffer, column/row counters, output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_buf   <= '0;
      k         <= '0;
      r         <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == S_WAIT_ROW && row_valid) begin
        row_buf <= row_in;
        k       <= '0;
      end

      if (state == S_FEED) begin
        if (k == LAST) begin
          k <= '0;
          r <= (r == LAST) ? '0 : r + CW'(1);
        end else begin
          k <= k + CW'(1);
        end
      end

      // A load wins over a drain so back-to-back results never drop out_valid.
      if (load) begin
        out_data  <= pool_result;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
